// File: rtl/sync_duram_fifo_pkg.sv
// Shared constants and status type for the synchronous dual-port-RAM FIFO.
// Pointers carry one wrap bit above the RAM address so full and empty can be told apart.
package sync_duram_fifo_pkg;

  typedef struct packed {
    logic full;
    logic empty;
    logic almostFull;
    logic almostEmpty;
  } fifo_status_t;

  function automatic int depthOf(input int addrWidth);
    return 1 << addrWidth;
  endfunction

  function automatic int ptrWidthOf(input int addrWidth);
    return addrWidth + 1;
  endfunction

endpackage

// File: rtl/sync_duram_fifo_mem.sv
// Simple dual-port storage: one write port and one registered read port.
// The array has no reset so that it maps onto block RAM.
module sync_duram_fifo_mem
  import sync_duram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  i_clock,
  input  logic                  i_wrEn,
  input  logic [ADDR_WIDTH-1:0] i_wrAddr,
  input  logic [DATA_WIDTH-1:0] i_wrData,
  input  logic                  i_rdEn,
  input  logic [ADDR_WIDTH-1:0] i_rdAddr,
  output logic [DATA_WIDTH-1:0] o_rdData
);

  logic [DATA_WIDTH-1:0] r_mem [depthOf(ADDR_WIDTH)];
  logic [DATA_WIDTH-1:0] r_rdData;

  always_ff @(posedge i_clock) begin
    if (i_wrEn) begin
      r_mem[i_wrAddr] <= i_wrData;
    end
    if (i_rdEn) begin
      r_rdData <= r_mem[i_rdAddr];
    end
  end

  assign o_rdData = r_rdData;

endmodule

// File: rtl/sync_duram_fifo.sv
// Synchronous FIFO built on a simple dual-port RAM with registered status flags.
// Define SYNC_DURAM_FIFO_FWFT_EN for first-word-fall-through; otherwise standard read latency.
module sync_duram_fifo
  import sync_duram_fifo_pkg::*;
#(
  parameter int DATA_WIDTH      = 32,
  parameter int ADDR_WIDTH      = 5,
  parameter int ALMOST_FULL_TH  = depthOf(ADDR_WIDTH) - 2,
  parameter int ALMOST_EMPTY_TH = 2
) (
  input  logic                  clock,
  input  logic                  reset_n,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic [ADDR_WIDTH:0]   usedw,
  output logic                  overflow,
  output logic                  underflow
);

  localparam int PTR_W = ptrWidthOf(ADDR_WIDTH);
  localparam int DEPTH = depthOf(ADDR_WIDTH);
  localparam logic [PTR_W-1:0] DEPTH_CNT = PTR_W'(DEPTH);
  localparam logic [PTR_W-1:0] AF_TH     = PTR_W'(ALMOST_FULL_TH);
  localparam logic [PTR_W-1:0] AE_TH     = PTR_W'(ALMOST_EMPTY_TH);

  logic [PTR_W-1:0]      r_wrPtr;
  logic [PTR_W-1:0]      r_rdPtr;
  logic [PTR_W-1:0]      r_usedw;
  fifo_status_t          r_status;
  logic                  r_rdValid;
  logic                  r_hasData;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_wrAccept;
  logic                  w_rdAccept;
  logic                  w_memRdEn;
  logic                  w_rdValidNext;
  logic [PTR_W-1:0]      w_wrPtrNext;
  logic [PTR_W-1:0]      w_rdPtrNext;
  logic [PTR_W-1:0]      w_usedwNext;
  fifo_status_t          w_statusNext;
  logic [DATA_WIDTH-1:0] w_memRdData;

  assign w_wrAccept = wr_en & ~r_status.full;

`ifdef SYNC_DURAM_FIFO_FWFT_EN
  logic w_ramEmpty;

  // The RAM read register doubles as the output stage; refill it whenever it is free or being popped.
  assign w_ramEmpty    = (r_wrPtr == r_rdPtr);
  assign w_rdAccept    = rd_en & r_rdValid;
  assign w_memRdEn     = ~w_ramEmpty & (~r_rdValid | w_rdAccept);
  assign w_rdValidNext = w_memRdEn | (r_rdValid & ~w_rdAccept);
`else
  assign w_rdAccept    = rd_en & ~r_status.empty;
  assign w_memRdEn     = w_rdAccept;
  assign w_rdValidNext = w_rdAccept;
`endif

  assign w_wrPtrNext = r_wrPtr + PTR_W'(w_wrAccept);
  assign w_rdPtrNext = r_rdPtr + PTR_W'(w_memRdEn);

  always_comb begin
    w_usedwNext = r_usedw;
    if (w_wrAccept && !w_rdAccept) begin
      w_usedwNext = r_usedw + PTR_W'(1);
    end else if (!w_wrAccept && w_rdAccept) begin
      w_usedwNext = r_usedw - PTR_W'(1);
    end

    w_statusNext             = '0;
    w_statusNext.almostFull  = (w_usedwNext >= AF_TH);
    w_statusNext.almostEmpty = (w_usedwNext <= AE_TH);
`ifdef SYNC_DURAM_FIFO_FWFT_EN
    // The output register holds a word too, so the pointers alone cannot give the occupancy.
    w_statusNext.full  = (w_usedwNext == DEPTH_CNT);
    w_statusNext.empty = (w_usedwNext == '0);
`else
    w_statusNext.full  = (w_wrPtrNext[ADDR_WIDTH] != w_rdPtrNext[ADDR_WIDTH]) &&
                         (w_wrPtrNext[ADDR_WIDTH-1:0] == w_rdPtrNext[ADDR_WIDTH-1:0]);
    w_statusNext.empty = (w_wrPtrNext == w_rdPtrNext);
`endif
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wrPtr     <= '0;
      r_rdPtr     <= '0;
      r_usedw     <= '0;
      r_status    <= '{full: 1'b0, empty: 1'b1, almostFull: 1'b0, almostEmpty: 1'b1};
      r_rdValid   <= 1'b0;
      r_hasData   <= 1'b0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      r_wrPtr     <= w_wrPtrNext;
      r_rdPtr     <= w_rdPtrNext;
      r_usedw     <= w_usedwNext;
      r_status    <= w_statusNext;
      r_rdValid   <= w_rdValidNext;
      r_hasData   <= r_hasData | w_memRdEn;
      r_overflow  <= wr_en & r_status.full;
      r_underflow <= rd_en & ~w_rdAccept;
    end
  end

  sync_duram_fifo_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_mem (
    .i_clock (clock),
    .i_wrEn  (w_wrAccept),
    .i_wrAddr(r_wrPtr[ADDR_WIDTH-1:0]),
    .i_wrData(wr_data),
    .i_rdEn  (w_memRdEn),
    .i_rdAddr(r_rdPtr[ADDR_WIDTH-1:0]),
    .o_rdData(w_memRdData)
  );

  // The RAM read register has no reset, so rd_data reads zero until a word has been fetched.
  assign rd_data      = r_hasData ? w_memRdData : '0;
  assign rd_valid     = r_rdValid;
  assign full         = r_status.full;
  assign empty        = r_status.empty;
  assign almost_full  = r_status.almostFull;
  assign almost_empty = r_status.almostEmpty;
  assign usedw        = r_usedw;
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

// File: tb/tb_sync_duram_fifo.sv
// Self-checking bench for sync_duram_fifo (DEPTH=4, thresholds 3/1) against a queue-based model.
// Honours SYNC_DURAM_FIFO_FWFT_EN so the same bench covers both read modes.
module tb_sync_duram_fifo;

  localparam int DW    = 8;
  localparam int AW    = 2;
  localparam int DEPTH = 4;
  localparam int AF_TH = 3;
  localparam int AE_TH = 1;

  logic          clock;
  logic          reset_n;
  logic          wr_en;
  logic [DW-1:0] wr_data;
  logic          rd_en;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          full;
  logic          empty;
  logic          almost_full;
  logic          almost_empty;
  logic [AW:0]   usedw;
  logic          overflow;
  logic          underflow;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] mQ[$];
  logic [DW-1:0] mRdData;
  logic          mRdValid;
  logic          mOvf;
  logic          mUnf;

  sync_duram_fifo #(
    .DATA_WIDTH     (DW),
    .ADDR_WIDTH     (AW),
    .ALMOST_FULL_TH (AF_TH),
    .ALMOST_EMPTY_TH(AE_TH)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .rd_valid    (rd_valid),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .almost_empty(almost_empty),
    .usedw       (usedw),
    .overflow    (overflow),
    .underflow   (underflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic int mCount();
`ifdef SYNC_DURAM_FIFO_FWFT_EN
    return mQ.size() + int'(mRdValid);
`else
    return mQ.size();
`endif
  endfunction

  task automatic modelReset();
    mQ.delete();
    mRdData  = '0;
    mRdValid = 1'b0;
    mOvf     = 1'b0;
    mUnf     = 1'b0;
  endtask

  task automatic modelEdge(input logic wr, input logic [DW-1:0] d, input logic rd);
    int  total;
    logic wrAcc;
    total = mCount();
    wrAcc = wr && (total < DEPTH);
    mOvf  = wr && (total == DEPTH);
`ifdef SYNC_DURAM_FIFO_FWFT_EN
    begin
      logic pop;
      logic fetch;
      pop   = rd && mRdValid;
      mUnf  = rd && !mRdValid;
      fetch = (mQ.size() > 0) && (!mRdValid || pop);
      if (fetch) begin
        mRdData  = mQ.pop_front();
        mRdValid = 1'b1;
      end else if (pop) begin
        mRdValid = 1'b0;
      end
    end
`else
    mUnf     = rd && (total == 0);
    mRdValid = rd && (total > 0);
    if (mRdValid) mRdData = mQ.pop_front();
`endif
    if (wrAcc) mQ.push_back(d);
  endtask

  task automatic checkVal(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic checkOutput(input string ctx);
    int cnt;
    cnt = mCount();
    checkVal({ctx, ".usedw"},        32'(usedw),        32'(cnt));
    checkVal({ctx, ".full"},         32'(full),         32'(cnt == DEPTH));
    checkVal({ctx, ".empty"},        32'(empty),        32'(cnt == 0));
    checkVal({ctx, ".almost_full"},  32'(almost_full),  32'(cnt >= AF_TH));
    checkVal({ctx, ".almost_empty"}, 32'(almost_empty), 32'(cnt <= AE_TH));
    checkVal({ctx, ".rd_valid"},     32'(rd_valid),     32'(mRdValid));
    checkVal({ctx, ".rd_data"},      32'(rd_data),      32'(mRdData));
    checkVal({ctx, ".overflow"},     32'(overflow),     32'(mOvf));
    checkVal({ctx, ".underflow"},    32'(underflow),    32'(mUnf));
  endtask

  task automatic checkReset(input string ctx);
    checkVal({ctx, ".usedw"},        32'(usedw),        32'd0);
    checkVal({ctx, ".empty"},        32'(empty),        32'd1);
    checkVal({ctx, ".almost_empty"}, 32'(almost_empty), 32'd1);
    checkVal({ctx, ".full"},         32'(full),         32'd0);
    checkVal({ctx, ".almost_full"},  32'(almost_full),  32'd0);
    checkVal({ctx, ".rd_valid"},     32'(rd_valid),     32'd0);
    checkVal({ctx, ".rd_data"},      32'(rd_data),      32'd0);
    checkVal({ctx, ".overflow"},     32'(overflow),     32'd0);
    checkVal({ctx, ".underflow"},    32'(underflow),    32'd0);
  endtask

  task automatic applyStimulus(input logic wr, input logic [DW-1:0] d, input logic rd, input string ctx);
    wr_en   = wr;
    wr_data = d;
    rd_en   = rd;
    @(posedge clock);
    modelEdge(wr, d, rd);
    #1;
    checkOutput(ctx);
  endtask

  task automatic drain(input string ctx);
    for (int k = 0; k < 3 * DEPTH && mCount() > 0; k++) applyStimulus(1'b0, '0, 1'b1, ctx);
    applyStimulus(1'b0, '0, 1'b0, ctx);
    checkVal({ctx, ".emptyAfterDrain"}, 32'(empty), 32'd1);
  endtask

  task automatic fillTo(input int n, input string ctx);
    for (int k = 0; k < 3 * DEPTH && mCount() < n; k++) applyStimulus(1'b1, DW'($urandom), 1'b0, ctx);
  endtask

  initial begin
    reset_n = 1'b1;
    wr_en   = 1'b0;
    rd_en   = 1'b0;
    wr_data = '0;
    modelReset();
    #2 reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1 checkReset("reset");
    @(negedge clock) reset_n = 1'b1;

    $display("[TB] boundary cases on empty FIFO");
    applyStimulus(1'b0, '0, 1'b1, "underflowEmpty");
    applyStimulus(1'b1, 8'h11, 1'b1, "wrRdEmpty");
    checkVal("wrRdEmpty.underflow", 32'(underflow), 32'd1);
    drain("drain0");

`ifdef SYNC_DURAM_FIFO_FWFT_EN
    $display("[TB] fall-through of a single word");
    applyStimulus(1'b1, 8'h55, 1'b0, "fwftWrite");
    applyStimulus(1'b0, '0, 1'b0, "fwftShow");
    checkVal("fwftShow.rd_data", 32'(rd_data), 32'h55);
    checkVal("fwftShow.rd_valid", 32'(rd_valid), 32'd1);
    applyStimulus(1'b0, '0, 1'b1, "fwftPop");
    checkVal("fwftPop.rd_valid", 32'(rd_valid), 32'd0);
    checkVal("fwftPop.empty", 32'(empty), 32'd1);
`endif

    $display("[TB] fill to full and overflow");
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b1, DW'(8'hA1 + i), 1'b0, "fill");
      checkVal("fill.usedwStep", 32'(usedw), 32'(i + 1));
    end
    checkVal("fill.full", 32'(full), 32'd1);
    applyStimulus(1'b1, 8'hA5, 1'b0, "overflowWrite");
    checkVal("overflowWrite.pulse", 32'(overflow), 32'd1);
    checkVal("overflowWrite.usedw", 32'(usedw), 32'd4);
    applyStimulus(1'b0, '0, 1'b0, "overflowClear");

`ifndef SYNC_DURAM_FIFO_FWFT_EN
    $display("[TB] drain in order and underflow");
    for (int i = 0; i < DEPTH; i++) begin
      applyStimulus(1'b0, '0, 1'b1, "drainRead");
      checkVal("drainRead.data", 32'(rd_data), 32'(8'hA1 + i));
      checkVal("drainRead.valid", 32'(rd_valid), 32'd1);
    end
    applyStimulus(1'b0, '0, 1'b1, "underflowRead");
    checkVal("underflowRead.pulse", 32'(underflow), 32'd1);
    checkVal("underflowRead.valid", 32'(rd_valid), 32'd0);
`endif
    drain("drain1");

    $display("[TB] steady write/read at two words");
    fillTo(2, "steadyFill");
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1'b1, DW'(8'hC0 + i), 1'b1, "steady");
      checkVal("steady.usedwConst", 32'(usedw), 32'd2);
    end

    $display("[TB] simultaneous access while full");
    fillTo(DEPTH, "fullFill");
    applyStimulus(1'b1, 8'hEE, 1'b1, "wrRdFull");
    checkVal("wrRdFull.overflow", 32'(overflow), 32'd1);
    drain("drain2");

    $display("[TB] randomized traffic");
    for (int i = 0; i < 300; i++) begin
      int p;
      p = ((i / 50) % 2 == 1) ? 30 : 70;
      applyStimulus(($urandom_range(0, 99) < p), DW'($urandom), ($urandom_range(0, 99) < (100 - p)), "random");
    end

    $display("[TB] reset during a read");
    drain("drain3");
    fillTo(3, "resetFill");
    wr_en = 1'b0;
    rd_en = 1'b1;
    @(negedge clock);
    reset_n = 1'b0;
    #1 checkReset("midReset");
    modelReset();
    @(posedge clock);
    @(negedge clock);
    rd_en   = 1'b0;
    reset_n = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, "postReset");
    applyStimulus(1'b0, '0, 1'b0, "postReset");
    checkVal("postReset.rd_valid", 32'(rd_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sync_duram_fifo.md
SYNC_DURAM_FIFO -- requirements
Module: sync_duram_fifo

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width in bits.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5; depth DEPTH = 2**ADDR_WIDTH words.
REQ-003 SHALL have parameter ALMOST_FULL_TH, default DEPTH-2; almost_full asserts when usedw >= this value.
REQ-004 SHALL have parameter ALMOST_EMPTY_TH, default 2; almost_empty asserts when usedw <= this value.
REQ-005 SHALL have port clock  in  1  sole clock; all logic on rising edge.
REQ-006 SHALL have port reset_n  in  1  asynchronous, active-low reset.
REQ-007 SHALL have port wr_en  in  1  write request.
REQ-008 SHALL have port wr_data  in  DATA_WIDTH  write word.
REQ-009 SHALL have port rd_en  in  1  read request (FWFT build: pop/acknowledge).
REQ-010 SHALL have port rd_data  out  DATA_WIDTH  read word, registered.
REQ-011 SHALL have port rd_valid  out  1  rd_data holds a valid word.
REQ-012 SHALL have ports full, empty, almost_full, almost_empty  out  1 each  registered status flags.
REQ-013 SHALL have port usedw  out  ADDR_WIDTH+1  stored word count, 0..DEPTH.
REQ-014 SHALL have ports overflow, underflow  out  1 each  one-cycle error pulses.

Function
REQ-015 Write SHALL be accepted on an edge with wr_en=1 and full=0; word stored at wr_ptr, wr_ptr increments modulo DEPTH.
REQ-016 wr_en=1 with full=1 SHALL discard the word, leave state unchanged, and pulse overflow for the following cycle.
REQ-017 Read SHALL be accepted on an edge with rd_en=1 and empty=0; rd_ptr increments modulo DEPTH.
REQ-018 rd_en=1 with empty=1 SHALL pulse underflow for the following cycle, state unchanged; rd_valid stays 0.
REQ-019 Pointers SHALL be ADDR_WIDTH+1 bits; full when MSBs differ and lower bits equal, empty when all bits equal.
REQ-020 Simultaneous accepted read and write SHALL leave usedw, full and empty unchanged.
REQ-021 Write while empty with simultaneous rd_en SHALL accept the write and reject the read (underflow pulse); no same-cycle bypass.
REQ-022 Write while full with simultaneous accepted read SHALL be rejected (overflow pulse); only the read takes effect.
REQ-023 All flags and usedw SHALL reflect state after the edge at which the access was accepted (one-cycle registered update).
REQ-024 Standard mode: rd_data SHALL present the accepted word one cycle after the read edge, with rd_valid=1 for exactly that cycle; rd_data holds its value otherwise.

Reset
REQ-025 reset_n low SHALL immediately clear pointers, usedw=0, empty=1, almost_empty=1, full=0, almost_full=0, rd_valid=0, rd_data=0, overflow=0, underflow=0.
REQ-026 Reset mid-operation SHALL abandon in-flight reads; storage array SHALL NOT be reset and contents are undefined thereafter.

Configuration
REQ-027 Macro SYNC_DURAM_FIFO_FWFT_EN SHALL select first-word-fall-through mode; absent, standard mode (REQ-024) applies.
REQ-028 With FWFT: head word SHALL be prefetched into rd_data; rd_valid=1 whenever rd_data holds an unpopped word; rd_en with rd_valid=1 pops it; rd_en with rd_valid=0 is underflow.
REQ-029 With FWFT: word written at edge N into an empty FIFO SHALL show rd_valid=1 after edge N+1; usedw and empty SHALL count the output register.

Structure
REQ-030 Package sync_duram_fifo_pkg SHALL hold pointer-width and depth constant functions and the FIFO status struct typedef.
REQ-031 Storage SHALL be sub-module sync_duram_fifo_mem: simple dual-port array, one write port, one registered read port, no reset, inferable as block RAM.

Verification (ADDR_WIDTH=2, DEPTH=4, thresholds 3/1)
REQ-032 Write 0xA1,0xA2,0xA3,0xA4 -> usedw 1..4, almost_full at 3, full at 4; fifth write 0xA5 -> overflow pulse, usedw stays 4.
REQ-033 Read four times from full -> rd_data 0xA1..0xA4 each with rd_valid one cycle later; empty after fourth; fifth read -> underflow pulse.
REQ-034 Steady simultaneous write/read for 10 cycles at usedw=2 -> usedw constant 2, data order preserved across pointer wrap.
REQ-035 Assert reset_n low with usedw=3 mid-read -> all outputs at reset values immediately, no rd_valid after release.
REQ-036 FWFT build: write 0x55 into empty FIFO -> rd_data=0x55, rd_valid=1 after next edge; rd_en pop -> rd_valid=0, empty=1.
